movavg_drv: RTL and testbench

- Driver for the movavg read/din/dout interface, sitting between an upstream valid/ready sample stream and a movavg instance.
- Buffers upstream samples in a small FIFO and hands one sample to movavg per read pulse on din.
- Captures dout a fixed latency after each read and returns it downstream on a valid/ready output with a single holding register.
- Flags FIFO underrun and result overrun.

---
 rtl/movavg_drv.sv | 136 +++++++++++++
 tb/tb_movavg_drv.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/movavg_drv.sv
// Feeds a movavg core from a valid/ready stream: a small FIFO supplies din on each read pulse,
// and a tag pipeline marks which dout values are real results to forward downstream.
module movavg_drv #(
  parameter int DEPTH   = 4,
  parameter int RES_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        read,
  output logic [63:0] din,
  input  logic [63:0] dout,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        underrun,
  output logic        overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [63:0]        mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [63:0]        din_q;
  logic [63:0]        out_data_q;
  logic               out_valid_q, out_valid_d;
  logic               underrun_q, overrun_q;
  logic [RES_LAT-1:0] tag_q;

  logic push, pop, empty, capture, hold_free;

  assign empty     = (count_q == '0);
  assign in_ready  = (count_q < FULL_CNT);
  assign push      = in_valid && in_ready;
  assign pop       = read && !empty;
  assign capture   = tag_q[RES_LAT-1];
  assign hold_free = !out_valid_q || out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (capture && hold_free) begin
      out_valid_d = 1'b1;
    end else if (!capture && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Storage has no reset; the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      din_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (read) begin
        din_q <= pop ? mem_q[rd_ptr_q] : '0;
      end
      if (read && empty) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // Stage RES_LAT-1 holds a read's tag during the cycle before edge E0+RES_LAT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q[0] <= 1'b0;
    end else begin
      tag_q[0] <= pop;
    end
  end

  generate
    for (genvar gi = 1; gi < RES_LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tag_q[gi] <= 1'b0;
        end else begin
          tag_q[gi] <= tag_q[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (capture && hold_free) begin
        out_data_q <= dout;
      end
      if (capture && !hold_free) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign din       = din_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_movavg_drv.sv
// Bench for movavg_drv: a behavioural 4-tap moving-sum core answers on dout after the
// driver's latency, and each scenario task checks its own outputs against hand-computed values.
module tb_movavg_drv;

  localparam int DEPTH   = 4;
  localparam int RES_LAT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        read = 1'b0;
  logic [63:0] din;
  logic [63:0] dout;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        underrun;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  movavg_drv #(.DEPTH(DEPTH), .RES_LAT(RES_LAT)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .read(read), .din(din), .dout(dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // movavg stand-in: sum of the last four samples, on dout in time for edge E0+5.
  logic [63:0] w0, w1, w2, s1, s2, s3, s4;
  logic        rd_d;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      w0 <= '0; w1 <= '0; w2 <= '0;
      s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0;
      rd_d <= 1'b0;
    end else begin
      rd_d <= read;
      if (rd_d) begin
        s1 <= din + w0 + w1 + w2;
        w0 <= din;
        w1 <= w0;
        w2 <= w1;
      end
      s2 <= s1;
      s3 <= s2;
      s4 <= s3;
    end
  end
  assign dout = s4;

  always @(posedge clk) begin
    if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    read = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [63:0] v);
    in_data = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic read_expect(input logic [63:0] exp_din, input logic [63:0] exp_res, input string name);
    int lat;
    lat = 0;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (din !== exp_din) begin
      errors++;
      $display("FAIL %s din got %h want %h", name, din, exp_din);
    end
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = k;
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL %s out_valid timeout got 0 want 1", name);
    end else begin
      checks++;
      if (out_data !== exp_res) begin
        errors++;
        $display("FAIL %s out_data got %h want %h", name, out_data, exp_res);
      end
      if (lat != RES_LAT) begin
        errors++;
        $display("FAIL %s latency got %0d want %0d", name, lat, RES_LAT);
      end
    end
    $display("read %s din=%h out_data=%h lat=%0d", name, din, out_data, lat);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || din !== 64'd0 || out_data !== 64'd0 || out_valid !== 1'b0 ||
        underrun !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals got rdy=%b din=%h od=%h ov=%b ur=%b or=%b want 1/0/0/0/0/0",
               in_ready, din, out_data, out_valid, underrun, overrun);
    end
    $display("reset checked");
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset();
    push(64'd1); push(64'd2); push(64'd3); push(64'd4);
    read_expect(64'd1, 64'd1, "s1");
    push(64'd5);
    read_expect(64'd2, 64'd3, "s2");
    read_expect(64'd3, 64'd6, "s3");
    read_expect(64'd4, 64'd10, "s4");
    read_expect(64'd5, 64'd14, "s5");
    checks++;
    if (underrun !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL stream_flags got ur=%b or=%b want 0/0", underrun, overrun);
    end
  endtask

  task automatic test_wrap();
    int h0;
    do_reset();
    h0 = hs_cnt;
    push(64'hFFFF_FFFF_FFFF_FFFF);
    push(64'd1);
    read_expect(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "w1");
    read_expect(64'd1, 64'd0, "w2");
    repeat (3) @(negedge clk);
    checks++;
    if (hs_cnt - h0 != 2) begin
      errors++;
      $display("FAIL wrap_pulses got %0d want 2", hs_cnt - h0);
    end
  endtask

  task automatic test_underrun();
    bit seen;
    do_reset();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (din !== 64'd0 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_flag got din=%h ur=%b want 0/1", din, underrun);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bubble_valid got 1 want 0");
    end
    $display("underrun bubble ur=%b seen=%b", underrun, seen);
    push(64'd7);
    read_expect(64'd7, 64'd7, "u7");
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    push(64'd5);
    push(64'd6);
    read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (din !== 64'd6) begin
      errors++;
      $display("FAIL ovr_din got %h want 6", din);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (out_data !== 64'd5 || out_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun got od=%h ov=%b or=%b want 5/1/1", out_data, out_valid, overrun);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drain got ov=%b or=%b want 0/1", out_valid, overrun);
    end
    $display("overrun od=%h ov=%b or=%b", out_data, out_valid, overrun);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_data = 64'(11 + i);
      in_valid = 1'b1;
      checks++;
      if (in_ready !== (i < DEPTH)) begin
        errors++;
        $display("FAIL full_rdy%0d got %b want %b", i, in_ready, (i < DEPTH));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    read_expect(64'd11, 64'd11, "f1");
    read_expect(64'd12, 64'd23, "f2");
    read_expect(64'd13, 64'd36, "f3");
    read_expect(64'd14, 64'd50, "f4");
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (underrun !== 1'b1 || din !== 64'd0) begin
      errors++;
      $display("FAIL full_extra got ur=%b din=%h want 1/0", underrun, din);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got [$];
    logic [63:0] exp_v [3];
    exp_v[0] = 64'd1; exp_v[1] = 64'd3; exp_v[2] = 64'd6;
    do_reset();
    push(64'd1); push(64'd2); push(64'd3);
    read = 1'b1;
    repeat (3) @(negedge clk);
    read = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_data);
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL b2b_%0d got %h want %h", i, got[i], exp_v[i]);
        end
      end
    end
    $display("back_to_back results=%0d", got.size());
  endtask

  task automatic test_reset_midflight();
    bit seen;
    do_reset();
    push(64'd9);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (din !== 64'd9) begin
      errors++;
      $display("FAIL mid_din got %h want 9", din);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (din !== 64'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset got din=%h rdy=%b ov=%b od=%h want 0/1/0/0",
               din, in_ready, out_valid, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_stale got 1 want 0");
    end
    $display("reset midflight seen=%b", seen);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_underrun();
    test_overrun();
    test_full();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
